// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package spi_pkg;

    localparam int CMD_W  = 10;
    localparam int DATA_W = 8;

    // Opcodes carried in rx_data[9:8]; the RAM decodes them, the slave only forwards
    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } spi_state_e;

    // Extract the opcode field of a command word
    function automatic logic [1:0] cmd_opcode(input logic [CMD_W-1:0] w);
        return w[CMD_W-1 -: 2];
    endfunction

endpackage

// File: rtl/spi_if.sv
// SPI pins plus the parallel RAM-side handshake of the SPI slave.
// Latency: none (wires only).
// Backpressure: none; rx_valid is a strobe, tx_valid a one-shot response.
interface spi_if;
    import spi_pkg::*;

    logic              SS_n;
    logic              MOSI;
    logic              MISO;
    logic [CMD_W-1:0]  rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;

    modport slave (
        input  SS_n,
        input  MOSI,
        output MISO,
        output rx_data,
        output rx_valid,
        input  tx_data,
        input  tx_valid
    );

    modport master (
        output SS_n,
        output MOSI,
        input  MISO,
        input  rx_data,
        input  rx_valid,
        output tx_data,
        output tx_valid
    );

endinterface

// File: rtl/spi_slave.sv
// SPI slave: deserialises 10-bit command words, serialises 8-bit RAM read data on MISO.
// Latency: rx_valid one cycle after the last MOSI bit; MISO bit 7 from the edge tx_valid is sampled.
// Backpressure: none; SS_n high aborts the frame, tx_valid is ignored outside the read-data wait.
module spi_slave
    import spi_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    spi_if.slave   bus
);

    spi_state_e        r_state;
    spi_state_e        w_next_state;

    logic [CMD_W-2:0]  r_shift;       // bits 9..1 of the word being received
    logic [3:0]        r_bit_cnt;     // 0..8 shifting bits 8..0, 9 = word done
    logic [CMD_W-1:0]  r_rx_data;
    logic              r_rx_valid;
    logic              r_rd_addr_seen;
    logic [DATA_W-2:0] r_out_shift;   // remaining read-data bits after bit 7
    logic [3:0]        r_out_cnt;     // 0 wait tx_valid, 1..7 shifting, 8 last bit out, 9 done
    logic              r_miso;
    logic              w_abort;

    // SS_n high in any active state terminates the frame on this edge
    assign w_abort = bus.SS_n && (r_state != IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; the first data bit picks write, read-address or read-data
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (!bus.SS_n) w_next_state = CHK_CMD;
            end
            CHK_CMD: begin
                if (bus.SS_n)           w_next_state = IDLE;
                else if (!bus.MOSI)     w_next_state = WRITE;
                else if (r_rd_addr_seen) w_next_state = READ_DATA;
                else                    w_next_state = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (bus.SS_n) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath and registered outputs: word assembly, rx strobe, read-data serialiser
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift        <= '0;
            r_bit_cnt      <= '0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_rd_addr_seen <= 1'b0;
            r_out_shift    <= '0;
            r_out_cnt      <= '0;
            r_miso         <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_abort) begin
                r_shift     <= '0;
                r_bit_cnt   <= '0;
                r_out_shift <= '0;
                r_out_cnt   <= '0;
                r_miso      <= 1'b0;
                // Last read bit already on the wire: the read is complete
                if (r_state == READ_DATA && r_out_cnt == 4'd8) begin
                    r_rd_addr_seen <= 1'b0;
                end
            end else begin
                case (r_state)
                    CHK_CMD: begin
                        r_shift   <= {{(CMD_W-2){1'b0}}, bus.MOSI};
                        r_bit_cnt <= '0;
                        r_out_cnt <= '0;
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (r_bit_cnt < 4'd9) begin
                            r_shift   <= {r_shift[CMD_W-3:0], bus.MOSI};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd8) begin
                                r_rx_data  <= {r_shift, bus.MOSI};
                                r_rx_valid <= 1'b1;
                                if (r_state == READ_ADD) r_rd_addr_seen <= 1'b1;
                            end
                        end else if (r_state == READ_DATA) begin
                            if (r_out_cnt == 4'd0) begin
                                if (bus.tx_valid) begin
                                    r_miso      <= bus.tx_data[DATA_W-1];
                                    r_out_shift <= bus.tx_data[DATA_W-2:0];
                                    r_out_cnt   <= 4'd1;
                                end
                            end else if (r_out_cnt < 4'd8) begin
                                r_miso      <= r_out_shift[DATA_W-2];
                                r_out_shift <= {r_out_shift[DATA_W-3:0], 1'b0};
                                r_out_cnt   <= r_out_cnt + 4'd1;
                            end else if (r_out_cnt == 4'd8) begin
                                r_miso         <= 1'b0;
                                r_rd_addr_seen <= 1'b0;
                                r_out_cnt      <= 4'd9;
                            end
                        end
                    end
                    default: begin
                        r_miso <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.MISO     = r_miso;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_slave.sv
// Directed self-checking bench for spi_slave with hand-computed expectations.
// Latency: checks rx_valid one cycle after the last bit and MISO from the tx_valid edge.
// Backpressure: the bench plays the RAM, answering tx_valid one cycle after rx_valid.
module tb_spi_slave;
    import spi_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   n_pulses;
    int   p0;

    spi_if bus();

    spi_slave dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rx_valid pulses, sampled away from the active edge
    always @(negedge clk) begin
        if (rst_n && bus.rx_valid) n_pulses = n_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // E0 plus E1..E10 carrying w[9:0]; returns 1 ns after E10 with SS_n still low
    task automatic shift_word(input logic [9:0] w);
        bus.SS_n = 1'b0;
        tick();
        for (int i = 9; i >= 0; i--) begin
            bus.MOSI = w[i];
            tick();
        end
    endtask

    task automatic end_frame();
        bus.SS_n = 1'b1;
        tick();
        check("end_state", 32'(dut.r_state), 32'(IDLE));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_miso;
        n_checks = 0;
        n_errors = 0;
        n_pulses = 0;
        rst_n        = 1'b0;
        bus.SS_n     = 1'b1;
        bus.MOSI     = 1'b0;
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_state", 32'(dut.r_state), 32'(IDLE));
        check("rst_miso", 32'(bus.MISO), 32'd0);
        check("rst_rx_data", 32'(bus.rx_data), 32'd0);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_rd_seen", 32'(dut.r_rd_addr_seen), 32'd0);
        rst_n = 1'b1;
        tick();

        // Reset asserted at E5 of a WRITE frame
        p0 = n_pulses;
        bus.SS_n = 1'b0;
        tick();
        for (int i = 9; i >= 6; i--) begin
            bus.MOSI = 1'(10'h0A5 >> i);
            tick();
        end
        check("mid_state_wr", 32'(dut.r_state), 32'(WRITE));
        bus.MOSI = 1'b1;
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_state", 32'(dut.r_state), 32'(IDLE));
        check("mid_rst_cnt", 32'(dut.r_bit_cnt), 32'd0);
        check("mid_rst_rx", 32'(bus.rx_data), 32'd0);
        bus.SS_n = 1'b1;
        tick();
        tick();
        check("mid_rst_rxv", 32'(bus.rx_valid), 32'd0);
        check("mid_rst_pulses", 32'(n_pulses - p0), 32'd0);
        rst_n = 1'b1;
        tick();

        // Write address
        p0 = n_pulses;
        shift_word(10'b00_1010_0101);
        check("wa_rxv", 32'(bus.rx_valid), 32'd1);
        check("wa_rx", 32'(bus.rx_data), 32'h0A5);
        check("wa_op", 32'(cmd_opcode(bus.rx_data)), 32'(OP_WR_ADDR));
        check("wa_state", 32'(dut.r_state), 32'(WRITE));
        tick();
        check("wa_rxv_low", 32'(bus.rx_valid), 32'd0);
        tick();
        check("wa_state_hold", 32'(dut.r_state), 32'(WRITE));
        end_frame();
        check("wa_pulses", 32'(n_pulses - p0), 32'd1);
        tick();

        // Write data
        p0 = n_pulses;
        shift_word(10'b01_1111_0000);
        check("wd_rx", 32'(bus.rx_data), 32'h1F0);
        check("wd_rxv", 32'(bus.rx_valid), 32'd1);
        tick();
        tick();
        end_frame();
        check("wd_pulses", 32'(n_pulses - p0), 32'd1);
        check("wd_rd_seen", 32'(dut.r_rd_addr_seen), 32'd0);
        tick();

        // Abort after 6 bits of a READ_ADD frame
        p0 = n_pulses;
        bus.SS_n = 1'b0;
        tick();
        for (int i = 9; i >= 4; i--) begin
            bus.MOSI = 1'(10'h2A5 >> i);
            tick();
        end
        check("ab_state", 32'(dut.r_state), 32'(READ_ADD));
        bus.SS_n = 1'b1;
        tick();
        check("ab_idle", 32'(dut.r_state), 32'(IDLE));
        check("ab_cnt", 32'(dut.r_bit_cnt), 32'd0);
        tick();
        check("ab_pulses", 32'(n_pulses - p0), 32'd0);
        check("ab_rd_seen", 32'(dut.r_rd_addr_seen), 32'd0);

        // Read address, following the abort
        p0 = n_pulses;
        shift_word(10'b10_1010_0101);
        check("ra_rx", 32'(bus.rx_data), 32'h2A5);
        check("ra_state", 32'(dut.r_state), 32'(READ_ADD));
        check("ra_rd_seen", 32'(dut.r_rd_addr_seen), 32'd1);
        tick();
        tick();
        end_frame();
        check("ra_pulses", 32'(n_pulses - p0), 32'd1);
        check("ra_rd_seen_kept", 32'(dut.r_rd_addr_seen), 32'd1);
        tick();

        // Read data: RAM answers 8'hC3 one cycle after rx_valid
        p0 = n_pulses;
        exp_miso = 8'b1100_0011;
        shift_word(10'b11_0101_1010);
        check("rd_state", 32'(dut.r_state), 32'(READ_DATA));
        check("rd_rx", 32'(bus.rx_data), 32'h35A);
        check("rd_rxv", 32'(bus.rx_valid), 32'd1);
        tick();
        check("rd_miso_idle", 32'(bus.MISO), 32'd0);
        bus.tx_data  = 8'hC3;
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        check("rd_miso_b7", 32'(bus.MISO), 32'(exp_miso[7]));
        for (int k = 6; k >= 0; k--) begin
            tick();
            check($sformatf("rd_miso_b%0d", k), 32'(bus.MISO), 32'(exp_miso[k]));
        end
        check("rd_seen_during", 32'(dut.r_rd_addr_seen), 32'd1);
        tick();
        check("rd_miso_tail", 32'(bus.MISO), 32'd0);
        check("rd_seen_clr", 32'(dut.r_rd_addr_seen), 32'd0);
        bus.tx_data  = 8'hFF;
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
        tick();
        check("rd_late_txv", 32'(bus.MISO), 32'd0);
        end_frame();
        check("rd_pulses", 32'(n_pulses - p0), 32'd1);
        tick();

        // Next read-opcode frame goes back to READ_ADD
        bus.SS_n = 1'b0;
        tick();
        bus.MOSI = 1'b1;
        tick();
        check("rd_again_state", 32'(dut.r_state), 32'(READ_ADD));
        bus.SS_n = 1'b1;
        tick();
        tick();

        // Back-to-back write frames, SS_n high for one cycle between
        p0 = n_pulses;
        shift_word(10'b00_0101_0101);
        check("bb1_rx", 32'(bus.rx_data), 32'h055);
        tick();
        bus.SS_n = 1'b1;
        tick();
        shift_word(10'b01_1100_0011);
        check("bb2_rx", 32'(bus.rx_data), 32'h1C3);
        check("bb2_rxv", 32'(bus.rx_valid), 32'd1);
        tick();
        end_frame();
        check("bb_pulses", 32'(n_pulses - p0), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
# spi_slave

Serial front end of the SPI memory subsystem. Deserialises 10-bit command words from an external SPI master into parallel words for the downstream 256x8 command-driven RAM (rx_data/rx_valid). It returns RAM read data (tx_data/tx_valid) to the master on MISO. Both sides share one clock; SPI bit clock equals clk.

## Interface
Parameters:
- none; widths are fixed by package constants (CMD_W = 10, DATA_W = 8)

Ports:
- clk  in  1  system/SPI clock; all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low
- SS_n  in  1  slave select, active-low; frames a transaction
- MOSI  in  1  serial data from master, MSB first, sampled on posedge clk
- MISO  out  1  serial read data to master, MSB first, registered
- rx_data  out  10  parallel command word to RAM; [9:8] opcode, [7:0] address/data
- rx_valid  out  1  one-cycle strobe, rx_data valid
- tx_data  in  8  read data from RAM
- tx_valid  in  1  RAM read data valid

## Operation
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: SS_n=0 -> CHK_CMD; else stay.
- CHK_CMD: sample MOSI as bit 9. MOSI=0 -> WRITE. MOSI=1 and rd_addr_seen=0 -> READ_ADD. MOSI=1 and rd_addr_seen=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA: shift in bits 8..0, one per cycle; 4-bit counter.
- After bit 0: rx_data <= assembled word and rx_valid pulses one cycle. The word is passed unchanged; opcode legality is the RAM's concern.
- WRITE and READ_ADD stay in state after the word until SS_n=1.
- READ_ADD completion sets rd_addr_seen.
- READ_DATA after the word: wait for tx_valid=1, latch tx_data into the 8-bit out-shift register, then drive bits 7..0 on MISO over the next 8 cycles. After bit 0, clear rd_addr_seen and drive MISO=0 until SS_n=1.
- SS_n=1 in any non-IDLE state -> IDLE on the next posedge.
  - Counters and shift registers are cleared.
  - An incomplete word produces no rx_valid.
  - rd_addr_seen is unchanged unless the READ_DATA output completed.
- tx_valid outside READ_DATA (after word sent) is ignored.

## Timing
- Reset: state=IDLE, MISO=0, rx_data=0, rx_valid=0, rd_addr_seen=0, counters=0. Asynchronous assert, synchronous-release use.
- Edge E0: SS_n sampled 0, IDLE->CHK_CMD.
- Edges E1..E10: MOSI bits 9..0.
- rx_valid=1 in the cycle after E10 (registered); deasserts after exactly 1 cycle.
- Read data path:
  - The RAM returns tx_valid one cycle after rx_valid.
  - Latch at the edge tx_valid is sampled high.
  - MISO carries bit 7 from that edge, then bits 6..0 on the following 7 edges.
  - Master keeps SS_n low at least 21 cycles for a READ_DATA frame, and at least 12 for the other frames.
- SS_n is sampled synchronously on clk; no metastability handling (same clock domain).
- Reset mid-frame: immediate return to reset values; rx_valid is never left high.

## Structure
- Package spi_pkg: state enum spi_state_e (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA), CMD_W, DATA_W, opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11.
- Single module spi_slave, with a 3-process FSM (state reg, next-state, outputs).
- No sub-module. Integration with the RAM is done in a separate top, spi_wrapper, which is not part of this block.

## Test plan
- Reset mid-frame: assert rst_n=0 at E5 of a WRITE frame -> all outputs 0, state IDLE, no rx_valid.
- Write address: frame MOSI=10'b00_1010_0101 -> rx_data=10'h0A5, rx_valid high exactly 1 cycle after E10; state WRITE until SS_n=1.
- Write data: frame 10'b01_1111_0000 -> rx_data=10'h1F0 with one rx_valid pulse; rd_addr_seen stays 0.
- Read address then read data:
  - Frame 10'b10_1010_0101 -> rx_data=10'h2A5, rd_addr_seen=1.
  - Next frame: first bit 1 goes to READ_DATA; word 10'h3xx gives rx_valid.
  - Drive tx_data=8'hC3 with tx_valid -> MISO sequence 1,1,0,0,0,0,1,1; rd_addr_seen cleared.
- Abort: SS_n=1 after 6 bits of a READ_ADD frame -> IDLE next edge, no rx_valid, rd_addr_seen stays 0. A following frame decodes cleanly.
- Back-to-back frames: SS_n high for 1 cycle between two write frames -> two distinct rx_valid pulses with correct words.
